// File: rtl/mc14500b_icu.sv
// MC14500B 1-bit industrial control unit: two-phase fetch/execute core with RR, IEN/OEN and flag outputs.
// Build option: define MC14500B_DEBUG_EN to expose the phase bit on state_out and the skip state on SKP.
module mc14500b_icu (
  input  logic       clk_in,
  input  logic       rst,
  output logic       clk_out,
  input  logic [3:0] I,
  output logic       FLGO,
  output logic       FLGF,
  output logic       RTN,
  output logic       JMP,
  inout  wire        data,
  output logic       RR,
  output logic       write,
  output logic       state_out,
  output logic       SKP
);

  typedef enum logic {
    FETCH = 1'b0,
    EXEC  = 1'b1
  } phase_t;

  typedef enum logic [3:0] {
    OP_NOPO = 4'h0,
    OP_LD   = 4'h1,
    OP_LDC  = 4'h2,
    OP_AND  = 4'h3,
    OP_ANDC = 4'h4,
    OP_OR   = 4'h5,
    OP_ORC  = 4'h6,
    OP_XNOR = 4'h7,
    OP_STO  = 4'h8,
    OP_STOC = 4'h9,
    OP_IEN  = 4'hA,
    OP_OEN  = 4'hB,
    OP_JMP  = 4'hC,
    OP_RTN  = 4'hD,
    OP_SKZ  = 4'hE,
    OP_NOPF = 4'hF
  } opcode_t;

  phase_t  phase, phase_next;
  opcode_t opcode;
  logic    din;
  logic    din_raw;
  logic    ien;
  logic    oen;
  logic    skip;
  logic    store_val;

  // Next-cycle values of the execute-phase state
  logic    rr_next;
  logic    ien_next;
  logic    oen_next;
  logic    skip_next;
  logic    flgo_next;
  logic    flgf_next;
  logic    rtn_next;
  logic    jmp_next;
  logic    write_next;
  logic    store_next;

  always_comb begin
    phase_next = (phase == FETCH) ? EXEC : FETCH;
  end

  always_comb begin
    rr_next    = RR;
    ien_next   = ien;
    oen_next   = oen;
    skip_next  = 1'b0;
    flgo_next  = 1'b0;
    flgf_next  = 1'b0;
    rtn_next   = 1'b0;
    jmp_next   = 1'b0;
    write_next = 1'b0;
    store_next = store_val;
    if (!skip) begin
      unique case (opcode)
        OP_NOPO: flgo_next = 1'b1;
        OP_LD:   rr_next   = din;
        OP_LDC:  rr_next   = ~din;
        OP_AND:  rr_next   = RR & din;
        OP_ANDC: rr_next   = RR & ~din;
        OP_OR:   rr_next   = RR | din;
        OP_ORC:  rr_next   = RR | ~din;
        OP_XNOR: rr_next   = ~(RR ^ din);
        OP_STO: begin
          if (oen) begin
            write_next = 1'b1;
            store_next = RR;
          end
        end
        OP_STOC: begin
          if (oen) begin
            write_next = 1'b1;
            store_next = ~RR;
          end
        end
        OP_IEN:  ien_next  = din_raw;
        OP_OEN:  oen_next  = din_raw;
        OP_JMP:  jmp_next  = 1'b1;
        OP_RTN: begin
          rtn_next  = 1'b1;
          skip_next = 1'b1;
        end
        OP_SKZ:  skip_next = ~RR;
        OP_NOPF: flgf_next = 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      phase     <= FETCH;
      opcode    <= OP_NOPO;
      din       <= 1'b0;
      din_raw   <= 1'b0;
      ien       <= 1'b1;
      oen       <= 1'b1;
      skip      <= 1'b0;
      RR        <= 1'b0;
      FLGO      <= 1'b0;
      FLGF      <= 1'b0;
      RTN       <= 1'b0;
      JMP       <= 1'b0;
      write     <= 1'b0;
      store_val <= 1'b0;
    end else begin
      phase <= phase_next;
      if (phase == FETCH) begin
        opcode <= opcode_t'(I);
        // While this block drives the bus, the line carries our own store value, so keep the last sample
        if (!write) begin
          din_raw <= data;
          din     <= data & ien;
        end
      end else begin
        RR        <= rr_next;
        ien       <= ien_next;
        oen       <= oen_next;
        skip      <= skip_next;
        FLGO      <= flgo_next;
        FLGF      <= flgf_next;
        RTN       <= rtn_next;
        JMP       <= jmp_next;
        write     <= write_next;
        store_val <= store_next;
      end
    end
  end

  assign data    = write ? store_val : 1'bz;
  assign clk_out = phase;

`ifdef MC14500B_DEBUG_EN
  assign state_out = phase;
  assign SKP       = skip;
`else
  assign state_out = 1'b0;
  assign SKP       = 1'b0;
`endif

endmodule

// File: tb/tb_mc14500b_icu.sv
// Directed bench for mc14500b_icu: one instruction per two clk_in cycles, results sampled after the execute edge.
module tb_mc14500b_icu;

  logic       clk_in;
  logic       rst;
  logic [3:0] I;
  logic       clk_out;
  logic       FLGO;
  logic       FLGF;
  logic       RTN;
  logic       JMP;
  logic       RR;
  logic       write;
  logic       state_out;
  logic       SKP;
  wire        data;
  logic       tb_en;
  logic       tb_val;

  int unsigned checks;
  int unsigned passed;

  assign data = tb_en ? tb_val : 1'bz;

  mc14500b_icu dut (
    .clk_in    (clk_in),
    .rst       (rst),
    .clk_out   (clk_out),
    .I         (I),
    .FLGO      (FLGO),
    .FLGF      (FLGF),
    .RTN       (RTN),
    .JMP       (JMP),
    .data      (data),
    .RR        (RR),
    .write     (write),
    .state_out (state_out),
    .SKP       (SKP)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
  endtask

  // Present op (and optionally drive data) for the fetch edge, release the bus, then run the execute edge
  task automatic instr(input logic [3:0] op, input logic drive, input logic val);
    I      = op;
    tb_en  = drive;
    tb_val = val;
    @(posedge clk_in);
    #1;
    tb_en = 1'b0;
    @(posedge clk_in);
    #1;
  endtask

  // Bus released by the DUT: whatever the bench drives must appear on the line
  task automatic chk_hiz(input string tag);
    tb_en  = 1'b1;
    tb_val = 1'b1;
    #1;
    chk({tag, "_hiz1"}, data, 1'b1);
    tb_val = 1'b0;
    #1;
    chk({tag, "_hiz0"}, data, 1'b0);
    tb_en = 1'b0;
  endtask

  initial begin
    checks = 0;
    passed = 0;
    tb_en  = 1'b0;
    tb_val = 1'b0;
    I      = 4'h0;
    rst    = 1'b0;
    #22;
    chk("rst_RR", RR, 1'b0);
    chk("rst_FLGO", FLGO, 1'b0);
    chk("rst_FLGF", FLGF, 1'b0);
    chk("rst_RTN", RTN, 1'b0);
    chk("rst_JMP", JMP, 1'b0);
    chk("rst_write", write, 1'b0);
    chk("rst_clk_out", clk_out, 1'b0);
    chk_hiz("rst_data");
    @(negedge clk_in);
    rst = 1'b1;

    // First edge after release is a fetch edge: clk_out high in execute phase
    I     = 4'h0;
    tb_en = 1'b1;
    tb_val = 1'b1;
    @(posedge clk_in);
    #1;
    tb_en = 1'b0;
    chk("fetch_clk_out", clk_out, 1'b1);
    chk("fetch_FLGO_pre", FLGO, 1'b0);
    @(posedge clk_in);
    #1;
    chk("nopo_FLGO", FLGO, 1'b1);
    chk("nopo_RR", RR, 1'b0);
    chk("exec_clk_out", clk_out, 1'b0);

    instr(4'h2, 1'b1, 1'b0);
    chk("ldc_FLGO", FLGO, 1'b0);
    chk("ldc_RR", RR, 1'b1);
    instr(4'hF, 1'b1, 1'b0);
    chk("nopf_FLGF", FLGF, 1'b1);
    chk("nopf_RR", RR, 1'b1);
    instr(4'h1, 1'b1, 1'b0);
    chk("ld0_RR", RR, 1'b0);
    chk("ld0_FLGF", FLGF, 1'b0);

    instr(4'h1, 1'b1, 1'b1);
    chk("ien_ld1_RR", RR, 1'b1);
    instr(4'hA, 1'b1, 1'b0);
    instr(4'h1, 1'b1, 1'b1);
    chk("ien_gated_RR", RR, 1'b0);
    instr(4'hA, 1'b1, 1'b1);
    instr(4'h1, 1'b1, 1'b1);
    chk("ien_restored_RR", RR, 1'b1);

    instr(4'h4, 1'b1, 1'b1);
    chk("andc_RR", RR, 1'b0);
    instr(4'h1, 1'b1, 1'b1);
    instr(4'h7, 1'b1, 1'b1);
    chk("xnor_RR", RR, 1'b1);
    instr(4'h3, 1'b1, 1'b0);
    chk("and_RR", RR, 1'b0);
    instr(4'h6, 1'b1, 1'b0);
    chk("orc_RR", RR, 1'b1);

    instr(4'hD, 1'b1, 1'b0);
    chk("rtn_RTN", RTN, 1'b1);
`ifdef MC14500B_DEBUG_EN
    chk("rtn_SKP", SKP, 1'b1);
`else
    chk("rtn_SKP", SKP, 1'b0);
`endif
    instr(4'h0, 1'b1, 1'b0);
    chk("skipped_FLGO", FLGO, 1'b0);
    chk("skipped_RTN", RTN, 1'b0);
    chk("skipped_SKP", SKP, 1'b0);
    instr(4'hC, 1'b1, 1'b0);
    chk("jmp_JMP", JMP, 1'b1);

    instr(4'h1, 1'b1, 1'b0);
    chk("ld0b_JMP", JMP, 1'b0);
    instr(4'hE, 1'b1, 1'b0);
`ifdef MC14500B_DEBUG_EN
    chk("skz_SKP", SKP, 1'b1);
`else
    chk("skz_SKP", SKP, 1'b0);
`endif
    instr(4'h1, 1'b1, 1'b1);
    chk("skz_skipped_RR", RR, 1'b0);
    instr(4'hE, 1'b1, 1'b0);
    instr(4'h1, 1'b1, 1'b1);
    chk("skz_rr0_still_skips", RR, 1'b0);

    instr(4'h1, 1'b1, 1'b1);
    instr(4'hE, 1'b1, 1'b0);
    instr(4'h5, 1'b1, 1'b0);
    chk("skz_rr1_no_skip_RR", RR, 1'b1);

    instr(4'h8, 1'b1, 1'b0);
    chk("sto_write", write, 1'b1);
    chk("sto_data", data, 1'b1);
    chk("sto_RR", RR, 1'b1);
    instr(4'h9, 1'b0, 1'b0);
    chk("stoc_write", write, 1'b1);
    chk("stoc_data", data, 1'b0);
    instr(4'hB, 1'b0, 1'b0);
    chk("oen_write", write, 1'b0);
    instr(4'h8, 1'b1, 1'b1);
    chk("sto_oen0_write", write, 1'b0);
    chk("sto_oen0_RR", RR, 1'b1);
    chk_hiz("sto_oen0_data");

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mc14500b_icu.md
Name:
mc14500b_icu

Overview:
- Cycle-accurate RTL model of the Motorola MC14500B 1-bit Industrial Control Unit (ICU).
- Decodes a 4-bit instruction stream and operates a 1-bit result register (RR) against a bidirectional 1-bit data line.
- Maintains input-enable (IEN) and output-enable (OEN) registers, and emits the NOP/JMP/RTN flags used by external program-counter logic.
- Each instruction takes two clk_in cycles: fetch, then execute.

Parameters:
- none

Ports:
- clk_in  input  1  system clock; all state updates on its rising edge
- rst  input  1  reset; asynchronous, active-low
- clk_out  output  1  instruction clock; equals the phase bit (1 during the execute phase)
- I  input  4  instruction opcode
- FLGO  output  1  NOPO flag
- FLGF  output  1  NOPF flag
- RTN  output  1  return flag
- JMP  output  1  jump flag
- data  inout  1  data bus; driven with the store value while write=1, otherwise high-Z
- RR  output  1  result register
- write  output  1  store strobe; marks data as driven by this block
- state_out  output  1  phase bit (0 = fetch, 1 = execute)
- SKP  output  1  high while the current instruction is being skipped

Behaviour:
- Reset (rst=0, async) clears phase, RR, FLGO, FLGF, RTN, JMP, write, SKP and the latched opcode/data. IEN and OEN reset to 1, so I/O is enabled out of reset. data is high-Z during reset.
- Phase toggles on every clk_in rising edge.
- Fetch edge (phase 0→1): latch I into the opcode register. Latch the data input as din = data & IEN; the bus value is sampled only when write=0.
- Execute edge (phase 1→0):
  - If a skip is pending: no architectural change; all four flags and write clear to 0; the skip pending bit clears.
  - Otherwise, clear all four flags and write, then apply the opcode below.
- Opcodes:
  - 0 NOPO: FLGO=1.
  - 1 LD: RR=din.
  - 2 LDC: RR=~din.
  - 3 AND: RR=RR&din.
  - 4 ANDC: RR=RR&~din.
  - 5 OR: RR=RR|din.
  - 6 ORC: RR=RR|~din.
  - 7 XNOR: RR=~(RR^din).
  - 8 STO: if OEN, write=1 and data is driven with RR.
  - 9 STOC: if OEN, write=1 and data is driven with ~RR.
  - A IEN: IEN=din_raw (bus value, not gated by IEN).
  - B OEN: OEN=din_raw.
  - C JMP: JMP=1.
  - D RTN: RTN=1; the next instruction is skipped.
  - E SKZ: if RR==0, the next instruction is skipped.
  - F NOPF: FLGF=1.
- Flags and write are level outputs. Each is held from the execute edge that sets it until the next execute edge.
- SKP asserts at the execute edge of RTN, or of SKZ with RR=0, and deasserts at the following execute edge.
- STO/STOC store the value only. RR is unchanged and is not overwritten by data read-back.
- Latency: every result is visible right after the execute edge, i.e. 2 clk_in cycles per instruction.
- Reset mid-instruction aborts the instruction. The next rising edge after release is a fetch edge.

Optional Feature:
- MC14500B_DEBUG_EN
  - Defined: state_out and SKP carry the phase bit and skip state as described above.
  - Not defined: state_out and SKP are tied to 0. All other behaviour is identical.

Test Plan:
- Reset: rst=0 → RR, FLGO, FLGF, RTN, JMP and write all 0; data is high-Z.
- Flags and loads:
  - NOPO with data=1 → FLGO=1, RR=0.
  - Next, LDC with data=0 → FLGO=0, RR=1.
  - Next, NOPF → FLGF=1, RR=1.
  - Next, LD with data=0 → RR=0, FLGF=0.
- IEN gating: LD 1 → RR=1; IEN with data 0; LD 1 → RR=0; IEN with data 1; LD 1 → RR=1.
- Logic unit ops:
  - Starting from RR=1, ANDC with data 1 → RR=0.
  - LD 1 followed by XNOR 1 → RR=1.
- Control flow:
  - RTN → RTN=1, SKP=1. The following NOPO is skipped: FLGO stays 0, RTN=0.
  - Next, JMP → JMP=1.
  - LD 0 then SKZ → SKP=1. The next LD 1 is skipped, so RR stays 0.
- Stores:
  - LD 1 then STO → write=1, data=1.
  - Next, OEN with data 0 followed by STO → write=0, data high-Z.
